pipelined_rca: RTL and testbench
================================

// Module: pipelined_rca
// PURPOSE
//  Pipelined ripple-carry adder/subtractor: WIDTH-bit operands split into STAGES equal slices,
//  one slice added per clock, carry registered between slices. Successor to the combinational
//  ripple-carry adder: adds carry-in, add/sub mode, signed overflow, valid/ready flow control.
//  Sits between operand producers and result consumers on datapaths too wide for one cycle.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; WIDTH % STAGES == 0, else elaboration error
//  STAGES   4  pipeline depth = number of slices; 1 <= STAGES <= WIDTH; slice width SW=WIDTH/STAGES
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts operand beat this cycle
//  sub        in   1      0: s = a + b + ci ; 1: s = a - b - ci
//  a          in   WIDTH  operand A (unsigned or two's complement)
//  b          in   WIDTH  operand B
//  ci         in   1      carry-in (add) / borrow-in (sub)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result beat
//  s          out  WIDTH  sum/difference, modulo 2^WIDTH
//  c          out  1      carry-out (add); NOT-borrow (sub), i.e. raw carry of a + ~b + ~ci
//  ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset: all stage valid bits, out_valid, s, c, ovf cleared to 0 immediately (async);
//    in-flight beats discarded; in_ready = 1 after deassertion (pipe empty).
//  - Sub mode: b_eff = ~b, ci_eff = ~ci; add mode: b_eff = b, ci_eff = ci. Mode travels with beat.
//  - Stage k (0..STAGES-1) adds slice [k*SW +: SW] of a and b_eff with carry from stage k-1
//    (stage 0 uses ci_eff). Upper slices of operands are skew-delayed; lower result slices
//    are deskew-delayed so s is presented whole in the final stage register.
//  - Latency: beat accepted at edge T (in_valid & in_ready) appears with out_valid=1 after
//    edge T+STAGES-1, i.e. STAGES register stages; throughput 1 beat/cycle when unstalled.
//  - Flow control: advance = ~out_valid | out_ready. All stages shift together on advance;
//    hold all stage registers when ~advance. in_ready = advance (combinational from out_ready).
//  - Empty stage bubbles propagate; their data is don't-care but s/c/ovf hold last value when
//    out_valid=0 is not required - verification checks outputs only when out_valid=1.
//  - Output beat held stable (s, c, ovf unchanged) while out_valid & ~out_ready.
//  - Simultaneous accept and emit in same cycle allowed; no beat lost or duplicated.
//  - STAGES=1: single register stage, behaves as registered full-width adder, latency 1.
//  - ovf computed in final stage from carry into bit WIDTH-1 and carry out; WIDTH=1 gives
//    ovf = c_in XOR c_out of the single bit.
// STRUCTURE
//  - Shared package/header: none required; slice-width and WIDTH%STAGES check as localparams.
//  - Sub-module rca_slice #(SW): combinational SW-bit ripple adder (a, b, ci -> s, co, c_msb),
//    chain of existing full_adder cells; c_msb = carry into slice MSB for overflow.
//  - Top: generate loop of STAGES rca_slice instances, per-stage valid/carry/mode registers,
//    triangular skew/deskew register arrays, one global advance enable.
// TESTING (WIDTH=8, STAGES=2 unless noted)
//  1 add a=0x0F b=0x01 ci=0 sub=0 -> after 2 cycles s=0x10 c=0 ovf=0 (carry crosses slice)
//  2 add a=0x7F b=0x01 ci=0 -> s=0x80 c=0 ovf=1; a=0xFF b=0x01 ci=1 -> s=0x01 c=1 ovf=0
//  3 sub a=0x05 b=0x07 ci=0 -> s=0xFE c=0 (borrow) ovf=0; a=0x80 b=0x01 ci=0 -> s=0x7F ovf=1
//  4 back-to-back 4 beats, out_ready low 3 cycles mid-stream -> in_ready low, output held,
//    all 4 results delivered in order, none lost/duplicated
//  5 rst asserted with 2 beats in flight -> out_valid=0, s=c=ovf=0 same cycle; no stale beat after
//  6 random 10k beats, random ready/valid, STAGES in {1,2,4,8}, WIDTH=32 -> match golden model

Source files
------------

// File: rtl/pipelined_rca_pkg.sv
// Shared types and helpers for the pipelined ripple-carry adder/subtractor.
package pipelined_rca_pkg;

   // Operation carried alongside each beat through the pipe.
   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Two's complement overflow: carry into the MSB disagrees with carry out of it.
   function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
      return c_into_msb ^ c_out_msb;
   endfunction

endpackage : pipelined_rca_pkg

// File: rtl/pipelined_rca_slice.sv
// Combinational building blocks: a one-bit full adder and an SW-bit ripple slice.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule : full_adder

// SW-bit ripple adder built from a chain of full adders.
// c_msb is the carry into the slice MSB, used for signed overflow on the top slice.
module rca_slice #(
   parameter int SW = 8
) (
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          ci,
   output logic [SW-1:0] s,
   output logic          co,
   output logic          c_msb
);
   // carry_chain[i] is the carry into bit i; carry_chain[SW] leaves the slice
   logic [SW:0] carry_chain;

   assign carry_chain[0] = ci;

   for (genvar gi = 0; gi < SW; gi++) begin : g_bit
      full_adder u_fa (
         .a  (a[gi]),
         .b  (b[gi]),
         .ci (carry_chain[gi]),
         .s  (s[gi]),
         .co (carry_chain[gi+1])
      );
   end

   assign co    = carry_chain[SW];
   assign c_msb = carry_chain[SW-1];
endmodule : rca_slice

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor with valid/ready flow control.
// Stage k adds operand slice k; upper operand slices ride along in shrinking
// skew registers, finished low result slices in growing deskew registers, so
// the last stage holds the full result together with carry-out and overflow.
module pipelined_rca
   import pipelined_rca_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c,
   output logic             ovf
);
   localparam int SW = WIDTH / STAGES;

   // Geometry must split evenly into at least one slice per stage.
   if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
      $error("pipelined_rca: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
   end

   // One enable moves every stage at once; a held output freezes the whole pipe.
   logic advance;

   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      // Number of low result bits finished once this stage has registered.
      localparam int DONE = (gi + 1) * SW;

      logic [SW-1:0]   op_a;
      logic [SW-1:0]   op_b_raw;
      logic [SW-1:0]   op_b;
      logic [SW-1:0]   sl_s;
      logic            cin;
      logic            sl_co;
      logic            sl_cmsb;
      logic            valid_in;
      op_e             mode_in;
      logic [DONE-1:0] sum_d;

      logic            valid_q;
      logic            carry_q;
      logic [DONE-1:0] sum_q;

      if (gi == 0) begin : g_in
         // First stage reads the ports directly; subtraction borrow-in becomes ~ci.
         assign op_a     = a[SW-1:0];
         assign op_b_raw = b[SW-1:0];
         assign mode_in  = sub ? OP_SUB : OP_ADD;
         assign cin      = ci ^ (mode_in == OP_SUB);
         assign valid_in = in_valid;
         assign sum_d    = sl_s;
      end else begin : g_in
         // Later stages pick the next slice off the previous stage's skew registers.
         assign op_a     = g_stage[gi-1].g_fwd.a_q[SW-1:0];
         assign op_b_raw = g_stage[gi-1].g_fwd.b_q[SW-1:0];
         assign mode_in  = g_stage[gi-1].g_fwd.mode_q;
         assign cin      = g_stage[gi-1].carry_q;
         assign valid_in = g_stage[gi-1].valid_q;
         assign sum_d    = {sl_s, g_stage[gi-1].sum_q};
      end

      // Subtraction adds the one's complement of B; inversion happens slice by slice.
      assign op_b = op_b_raw ^ {SW{mode_in == OP_SUB}};

      rca_slice #(
         .SW (SW)
      ) u_slice (
         .a     (op_a),
         .b     (op_b),
         .ci    (cin),
         .s     (sl_s),
         .co    (sl_co),
         .c_msb (sl_cmsb)
      );

      // Valid bit, inter-slice carry and finished result bits advance together.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
         end else if (advance) begin
            valid_q <= valid_in;
            carry_q <= sl_co;
            sum_q   <= sum_d;
         end
      end

      if (gi < STAGES - 1) begin : g_fwd
         // Operand bits not yet consumed, plus the beat's mode, for later stages.
         localparam int OW = WIDTH - DONE;

         logic [OW-1:0] a_d;
         logic [OW-1:0] b_d;
         logic [OW-1:0] a_q;
         logic [OW-1:0] b_q;
         op_e           mode_q;
         logic          cmsb_unused;

         // Only the top slice's MSB carry feeds overflow.
         assign cmsb_unused = sl_cmsb;

         if (gi == 0) begin : g_src
            assign a_d = a[WIDTH-1:SW];
            assign b_d = b[WIDTH-1:SW];
         end else begin : g_src
            assign a_d = g_stage[gi-1].g_fwd.a_q[OW+SW-1:SW];
            assign b_d = g_stage[gi-1].g_fwd.b_q[OW+SW-1:SW];
         end

         // Skew registers delay upper operand slices until their stage comes up.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_q    <= '0;
               b_q    <= '0;
               mode_q <= OP_ADD;
            end else if (advance) begin
               a_q    <= a_d;
               b_q    <= b_d;
               mode_q <= mode_in;
            end
         end
      end else begin : g_last
         logic ovf_q;

         // Overflow is taken from the top slice as it finishes.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (advance) begin
               ovf_q <= signed_ovf(sl_cmsb, sl_co);
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].valid_q;
   assign s         = g_stage[STAGES-1].sum_q;
   assign c         = g_stage[STAGES-1].carry_q;
   assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule : pipelined_rca

// File: tb/tb_pipelined_rca.sv
// Self-checking bench: directed corner beats, stall/reset scenarios and a long
// randomized valid/ready run scored against an arithmetic reference model.
module tb_pipelined_rca;
   localparam int W      = 8;
   localparam int S      = 2;
   localparam int N_RAND = 10000;
   localparam int BUDGET = 40000;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         ovf;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ci;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         c;
   logic         ovf;

   int   checks    = 0;
   int   errors    = 0;
   int   delivered = 0;
   res_t exp_q[$];

   always #5 clk = ~clk;

   pipelined_rca #(
      .WIDTH  (W),
      .STAGES (S)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sub       (sub),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .c         (c),
      .ovf       (ovf)
   );

   // Single comparison point: counts every check, reports each mismatch.
   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: integer arithmetic, carry = no unsigned wrap (add) / no borrow (sub),
   // overflow = true signed result outside the W-bit signed range.
   function automatic res_t model(input logic sb, input logic [W-1:0] av,
                                  input logic [W-1:0] bv, input logic civ);
      res_t   r;
      longint ua   = longint'(av);
      longint ub   = longint'(bv);
      longint sa   = longint'($signed(av));
      longint sbv  = longint'($signed(bv));
      longint lim  = longint'(1) << (W - 1);
      longint full;
      longint sres;
      if (sb) begin
         full = ua - ub - longint'(civ);
         sres = sa - sbv - longint'(civ);
         r.c  = (full >= 0);
      end else begin
         full = ua + ub + longint'(civ);
         sres = sa + sbv + longint'(civ);
         r.c  = (full >= (longint'(1) << W));
      end
      r.s   = full[W-1:0];
      r.ovf = (sres >= lim) || (sres < -lim);
      return r;
   endfunction

   // One clock cycle: drive at negedge, check handshake and output beat, score.
   task automatic step(input logic iv, input logic ordy, input logic sb,
                       input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ,
                       output logic accepted);
      res_t head;
      @(negedge clk);
      in_valid  = iv;
      out_ready = ordy;
      sub       = sb;
      a         = av;
      b         = bv;
      ci        = civ;
      #1;
      check_eq("in_ready", in_ready, !out_valid || ordy);
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("stale_beat", out_valid, 1'b0);
         end else begin
            head = exp_q[0];
            check_eq("s", s, head.s);
            check_eq("c", c, head.c);
            check_eq("ovf", ovf, head.ovf);
            if (ordy) begin
               void'(exp_q.pop_front());
               delivered++;
               $display("beat %0d: s=%0h c=%0b ovf=%0b", delivered, s, c, ovf);
            end
         end
      end
      accepted = iv && in_ready;
      if (accepted) exp_q.push_back(model(sb, av, bv, civ));
   endtask

   // Single beat into an empty pipe: checks latency and the documented result.
   task automatic directed(input string tag, input logic sb, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input logic civ,
                           input logic [W-1:0] es, input logic ec, input logic eo);
      logic acc;
      step(1'b1, 1'b1, sb, av, bv, civ, acc);
      check_eq({tag, "_accept"}, acc, 1'b1);
      for (int k = 0; k < S; k++) begin
         step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, acc);
         check_eq({tag, "_latency"}, out_valid, (k == S - 1));
         if (k == S - 1) begin
            check_eq({tag, "_s"}, s, es);
            check_eq({tag, "_c"}, c, ec);
            check_eq({tag, "_ovf"}, ovf, eo);
         end
      end
   endtask

   function automatic logic [W-1:0] rand_operand();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = '1;
         1:       v = {1'b1, {(W-1){1'b0}}};
         2:       v = {1'b0, {(W-1){1'b1}}};
         3:       v = '0;
         default: v = W'($urandom);
      endcase
      return v;
   endfunction

   initial begin
      logic acc;
      logic rdy;
      logic saw_stall;
      int   sent;
      int   cyc;
      int   d0;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sub       = 1'b0;
      a         = '0;
      b         = '0;
      ci        = 1'b0;
      #1;
      check_eq("reset_out_valid", out_valid, 1'b0);
      check_eq("reset_s", s, '0);
      check_eq("reset_c", c, 1'b0);
      check_eq("reset_ovf", ovf, 1'b0);
      check_eq("reset_in_ready", in_ready, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Directed arithmetic corners
      directed("add_slice_carry", 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
      directed("add_ovf",         1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      directed("add_wrap_ci",     1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
      directed("sub_borrow",      1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
      directed("sub_ovf",         1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
      directed("sub_borrow_in",   1'b1, 8'h10, 8'h05, 1'b1, 8'h0A, 1'b1, 1'b0);

      // Four back-to-back beats with the consumer stalled for three cycles
      sent      = 0;
      saw_stall = 1'b0;
      d0        = delivered;
      for (int k = 0; k < 14; k++) begin
         rdy = !(k >= 2 && k <= 4);
         step(sent < 4, rdy, 1'($urandom), rand_operand(), rand_operand(), 1'($urandom), acc);
         if (!in_ready) saw_stall = 1'b1;
         if (acc) sent++;
      end
      check_eq("stall_sent", sent, 4);
      check_eq("stall_in_ready_low", saw_stall, 1'b1);
      check_eq("stall_delivered", delivered - d0, 4);
      check_eq("stall_drained", exp_q.size(), 0);

      // Reset with two beats in flight
      step(1'b1, 1'b0, 1'b0, 8'h7F, 8'h01, 1'b0, acc);
      step(1'b1, 1'b0, 1'b0, 8'h33, 8'h44, 1'b1, acc);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check_eq("inflight_valid", out_valid, 1'b1);
      rst = 1'b1;
      #1;
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_s", s, '0);
      check_eq("rst_c", c, 1'b0);
      check_eq("rst_ovf", ovf, 1'b0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("post_rst_in_ready", in_ready, 1'b1);
      for (int k = 0; k < S + 3; k++) begin
         step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, acc);
         check_eq("post_rst_idle", out_valid, 1'b0);
      end

      // Randomized traffic with random valid and ready
      sent = 0;
      cyc  = 0;
      d0   = delivered;
      while (sent < N_RAND && cyc < BUDGET) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
              rand_operand(), rand_operand(), 1'($urandom), acc);
         if (acc) sent++;
         cyc++;
      end
      for (int k = 0; k < S + 4; k++) begin
         step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, acc);
      end
      check_eq("rand_sent", sent, N_RAND);
      check_eq("rand_delivered", delivered - d0, N_RAND);
      check_eq("rand_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pipelined_rca
